// File: rtl/mmu_pkg.sv
// Shared types and helpers for the streaming matrix multiply-accumulate unit.
// Defaults, FSM state encoding, rounding/saturation and width checks.
package mmu_pkg;

  localparam int DEF_NUM_ROWS_A = 2;
  localparam int DEF_NUM_COLS_B = 2;
  localparam int DEF_K_CHUNK    = 2;
  localparam int DEF_NUM_CHUNKS = 4;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_FIXED_PNT  = 8;
  localparam int DEF_ACC_WIDTH  = 40;
  localparam int K_TOTAL = DEF_K_CHUNK * DEF_NUM_CHUNKS;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic               sat;
    logic signed [63:0] val;
  } rs_t;

  // Round half toward +inf, then clip to a dw-bit signed range.
  function automatic rs_t round_sat(
    input logic signed [63:0] acc,
    input int                 fp,
    input int                 dw
  );
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    rs_t o;
    r  = (acc + (64'sd1 <<< (fp - 1))) >>> fp;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    o.sat = (r > hi) || (r < lo);
    if (r > hi)      o.val = hi;
    else if (r < lo) o.val = lo;
    else             o.val = r;
    return o;
  endfunction

  function automatic bit acc_width_ok(
    input int aw,
    input int dw,
    input int kt
  );
    return (aw >= 2 * dw + $clog2(kt + 1) + 1) && (aw <= 64);
  endfunction

endpackage

// File: rtl/mmu_if.sv
// Job, operand-chunk and result handshake bundle for mmu_stream.
// master = operand fetch / writeback side, slave = the MAC unit.
interface mmu_if
  import mmu_pkg::*;
#(
  parameter int NUM_ROWS_A = DEF_NUM_ROWS_A,
  parameter int NUM_COLS_B = DEF_NUM_COLS_B,
  parameter int K_CHUNK    = DEF_K_CHUNK,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  logic start;
  logic bias_en;
  logic [NUM_ROWS_A-1:0][NUM_COLS_B-1:0][DATA_WIDTH-1:0] mat_in_accum;
  logic in_valid;
  logic in_ready;
  logic [NUM_ROWS_A-1:0][K_CHUNK-1:0][DATA_WIDTH-1:0] mat_a_chunk;
  logic [K_CHUNK-1:0][NUM_COLS_B-1:0][DATA_WIDTH-1:0] mat_b_chunk;
  logic out_valid;
  logic out_ready;
  logic [NUM_ROWS_A-1:0][NUM_COLS_B-1:0][DATA_WIDTH-1:0] mat_out;
  logic sat_flag;
  logic busy;

  modport master (
    output start, bias_en, mat_in_accum,
    output in_valid, mat_a_chunk, mat_b_chunk,
    output out_ready,
    input  in_ready, out_valid, mat_out,
    input  sat_flag, busy
  );

  modport slave (
    input  start, bias_en, mat_in_accum,
    input  in_valid, mat_a_chunk, mat_b_chunk,
    input  out_ready,
    output in_ready, out_valid, mat_out,
    output sat_flag, busy
  );
endinterface

// File: rtl/mmu_acc_cell.sv
// One output cell: chunk dot product, product register, full-precision
// accumulator and rounded/saturated result register.
module mmu_acc_cell
  import mmu_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIXED_PNT  = DEF_FIXED_PNT,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int K_CHUNK    = DEF_K_CHUNK
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_bias,
  input  logic bias_en,
  input  logic [DATA_WIDTH-1:0] bias,
  input  logic beat,
  input  logic accum_en,
  input  logic finish,
  input  logic [K_CHUNK-1:0][DATA_WIDTH-1:0] a,
  input  logic [K_CHUNK-1:0][DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] val,
  output logic sat
);

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0] dot;
  logic signed [ACC_WIDTH-1:0] psum;
  logic signed [ACC_WIDTH-1:0] acc;
  rs_t rs;
  logic unused_hi;

  always_comb begin
    prod = '0;
    dot  = '0;
    for (int k = 0; k < K_CHUNK; k++) begin
      prod = $signed(a[k]) * $signed(b[k]);
      dot  = dot + ACC_WIDTH'(prod);
    end
  end

  always_comb begin
    rs  = round_sat(64'(acc), FIXED_PNT, DATA_WIDTH);
    sat = rs.sat;
  end

  assign unused_hi = ^rs.val[63:DATA_WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psum <= '0;
      acc  <= '0;
      val  <= '0;
    end else begin
      if (beat) psum <= dot;
      if (load_bias)
        acc <= bias_en ? (ACC_WIDTH'($signed(bias)) <<< FIXED_PNT) : '0;
      else if (accum_en)
        acc <= acc + psum;
      if (finish) val <= rs.val[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/mmu_stream.sv
// Streaming fixed-point C = A*B (+ bias) with chunked inner dimension.
// Control FSM plus a grid of accumulator cells.
module mmu_stream
  import mmu_pkg::*;
#(
  parameter int NUM_ROWS_A = DEF_NUM_ROWS_A,
  parameter int NUM_COLS_B = DEF_NUM_COLS_B,
  parameter int K_CHUNK    = DEF_K_CHUNK,
  parameter int NUM_CHUNKS = DEF_NUM_CHUNKS,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIXED_PNT  = DEF_FIXED_PNT,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
  input logic clk,
  input logic rst_n,
  mmu_if.slave bus
);

  localparam int KT = K_CHUNK * NUM_CHUNKS;
  localparam int CW = $clog2(NUM_CHUNKS + 1);
  localparam int NC = NUM_ROWS_A * NUM_COLS_B;

  if (!acc_width_ok(ACC_WIDTH, DATA_WIDTH, KT)) begin : g_bad_acc
    $fatal(1, "mmu_stream: ACC_WIDTH too small for exact accumulation");
  end

  state_t state;
  logic [CW-1:0] cnt;
  logic pv;
  logic out_valid_q;
  logic sat_q;
  logic accept;
  logic load_bias;
  logic finish;
  logic [NC-1:0] cell_sat;
  logic [NUM_ROWS_A-1:0][NUM_COLS_B-1:0][DATA_WIDTH-1:0] mat_q;

  assign bus.in_ready  = (state == LOAD);
  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.sat_flag  = sat_q;
  assign bus.mat_out   = mat_q;

  assign accept    = bus.in_valid & bus.in_ready;
  assign load_bias = (state == IDLE) & bus.start;
  // The last product must have reached the accumulator before rounding.
  assign finish    = (state == DRAIN) & ~pv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      pv          <= 1'b0;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      pv <= accept;
      unique case (state)
        IDLE: if (bus.start) begin
          cnt   <= '0;
          sat_q <= 1'b0;
          state <= LOAD;
        end
        LOAD: if (accept) begin
          cnt <= cnt + CW'(1);
          if (cnt == CW'(NUM_CHUNKS - 1)) state <= DRAIN;
        end
        DRAIN: if (!pv) begin
          sat_q       <= |cell_sat;
          out_valid_q <= 1'b1;
          state       <= DONE;
        end
        DONE: if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  for (genvar r = 0; r < NUM_ROWS_A; r++) begin : g_row
    for (genvar c = 0; c < NUM_COLS_B; c++) begin : g_col
      logic [K_CHUNK-1:0][DATA_WIDTH-1:0] bcol;
      for (genvar k = 0; k < K_CHUNK; k++) begin : g_k
        assign bcol[k] = bus.mat_b_chunk[k][c];
      end
      mmu_acc_cell #(
        .DATA_WIDTH(DATA_WIDTH),
        .FIXED_PNT (FIXED_PNT),
        .ACC_WIDTH (ACC_WIDTH),
        .K_CHUNK   (K_CHUNK)
      ) u_cell (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_bias(load_bias),
        .bias_en  (bus.bias_en),
        .bias     (bus.mat_in_accum[r][c]),
        .beat     (accept),
        .accum_en (pv),
        .finish   (finish),
        .a        (bus.mat_a_chunk[r]),
        .b        (bcol),
        .val      (mat_q[r][c]),
        .sat      (cell_sat[r*NUM_COLS_B+c])
      );
    end
  end

endmodule

// File: tb/tb_mmu_stream.sv
// Directed bench for mmu_stream: bias, saturation, rounding,
// backpressure and mid-job reset against hand-computed results.
module tb_mmu_stream;
  import mmu_pkg::*;

  typedef logic [1:0][1:0][15:0] mat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mmu_if ifc ();

  mmu_stream dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc)
  );

  int n_chk = 0;
  int n_pass = 0;
  mat_t a_beats [4];
  mat_t b_beats [4];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  function automatic mat_t fill(input logic [15:0] v);
    return {4{v}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_uniform(input logic [15:0] a, input logic [15:0] b);
    for (int i = 0; i < 4; i++) begin
      a_beats[i] = fill(a);
      b_beats[i] = fill(b);
    end
  endtask

  task automatic start_job(input bit be, input logic [15:0] bias);
    ifc.bias_en = be;
    ifc.mat_in_accum = fill(bias);
    ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
    chk("busy_after_start", ifc.busy, 1);
  endtask

  task automatic send_beats(input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      ifc.mat_a_chunk = a_beats[i];
      ifc.mat_b_chunk = b_beats[i];
      ifc.in_valid = 1'b1;
      chk("in_ready_load", ifc.in_ready, 1);
      tick();
      ifc.in_valid = 1'b0;
      if (gap && i < n - 1) tick();
    end
  endtask

  task automatic run_job(input bit be, input logic [15:0] bias,
                         input bit gap, input mat_t exp,
                         input bit exp_sat, input bit hold);
    start_job(be, bias);
    send_beats(4, gap);
    chk("lat_n0", ifc.out_valid, 0);
    tick();
    chk("lat_n1", ifc.out_valid, 0);
    tick();
    chk("lat_n2", ifc.out_valid, 1);
    chk("mat_out", ifc.mat_out, exp);
    chk("sat_flag", ifc.sat_flag, exp_sat);
    if (hold) begin
      for (int i = 0; i < 5; i++) begin
        if (i == 2) ifc.start = 1'b1;
        tick();
        ifc.start = 1'b0;
        chk("hold_valid", ifc.out_valid, 1);
        chk("hold_mat", ifc.mat_out, exp);
        chk("hold_in_ready", ifc.in_ready, 0);
        chk("hold_busy", ifc.busy, 1);
      end
    end
    ifc.out_ready = 1'b1;
    tick();
    ifc.out_ready = 1'b0;
    chk("valid_drop", ifc.out_valid, 0);
    chk("idle_busy", ifc.busy, 0);
    chk("mat_retain", ifc.mat_out, exp);
  endtask

  task automatic round_job(input logic [15:0] bv, input logic [15:0] ev);
    mat_t e;
    load_uniform(16'h0000, 16'h0000);
    a_beats[0][0][0] = 16'h0001;
    b_beats[0][0][0] = bv;
    e = '0;
    e[0][0] = ev;
    run_job(1'b0, 16'h0000, 1'b0, e, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.start = 1'b0;
    ifc.bias_en = 1'b0;
    ifc.mat_in_accum = '0;
    ifc.in_valid = 1'b0;
    ifc.mat_a_chunk = '0;
    ifc.mat_b_chunk = '0;
    ifc.out_ready = 1'b0;
    #12;
    chk("rst_out_valid", ifc.out_valid, 0);
    chk("rst_in_ready", ifc.in_ready, 0);
    chk("rst_busy", ifc.busy, 0);
    chk("rst_mat", ifc.mat_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    // Input valid in IDLE must be ignored.
    ifc.in_valid = 1'b1;
    tick();
    chk("idle_in_ready", ifc.in_ready, 0);
    chk("idle_busy0", ifc.busy, 0);
    ifc.in_valid = 1'b0;

    load_uniform(16'h0100, 16'h0100);
    run_job(1'b0, 16'h0000, 1'b0, fill(16'h0800), 1'b0, 1'b0);

    load_uniform(16'h0100, 16'h0080);
    run_job(1'b1, 16'h0080, 1'b0, fill(16'h0480), 1'b0, 1'b0);

    load_uniform(16'h7FFF, 16'h7FFF);
    run_job(1'b0, 16'h0000, 1'b0, fill(16'h7FFF), 1'b1, 1'b0);
    load_uniform(16'h7FFF, 16'h8000);
    run_job(1'b0, 16'h0000, 1'b0, fill(16'h8000), 1'b1, 1'b0);
    load_uniform(16'h0100, 16'h0100);
    run_job(1'b0, 16'h0000, 1'b0, fill(16'h0800), 1'b0, 1'b0);

    round_job(16'h0080, 16'h0001);
    round_job(16'h007F, 16'h0000);
    round_job(16'hFF80, 16'h0000);

    load_uniform(16'h0100, 16'h0100);
    run_job(1'b0, 16'h0000, 1'b1, fill(16'h0800), 1'b0, 1'b0);
    run_job(1'b0, 16'h0000, 1'b0, fill(16'h0800), 1'b0, 1'b1);

    // Leave a saturated result visible, then reset mid-job.
    load_uniform(16'h7FFF, 16'h7FFF);
    run_job(1'b0, 16'h0000, 1'b0, fill(16'h7FFF), 1'b1, 1'b0);
    load_uniform(16'h0100, 16'h0100);
    start_job(1'b0, 16'h0000);
    send_beats(2, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_mat", ifc.mat_out, 0);
    chk("mid_rst_valid", ifc.out_valid, 0);
    chk("mid_rst_busy", ifc.busy, 0);
    chk("mid_rst_in_ready", ifc.in_ready, 0);
    chk("mid_rst_sat", ifc.sat_flag, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_job(1'b0, 16'h0000, 1'b0, fill(16'h0800), 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mmu_stream.md
Name: mmu_stream

Overview:
Streaming, parametrised matrix multiply-accumulate unit (Q-format fixed point) computing C = A*B (+ bias).
- The shared inner dimension K is delivered as NUM_CHUNKS chunks of K_CHUNK columns of A and rows of B, each chunk accepted through a valid/ready handshake.
- Accumulation is full precision, with a single round-and-saturate at the end and an output valid/ready handshake.
- Sits between the operand-fetch logic and the result writeback of the datapath.

Parameters:
NUM_ROWS_A, 2, rows of A and C
NUM_COLS_B, 2, columns of B and C
K_CHUNK, 2, inner-dimension elements per input beat
NUM_CHUNKS, 4, beats per job (K_TOTAL = K_CHUNK*NUM_CHUNKS)
DATA_WIDTH, 16, operand/result width, signed
FIXED_PNT, 8, fractional bits
ACC_WIDTH, 40, internal accumulator width, signed

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  job start pulse; honoured only in IDLE
bias_en  in  1  sampled with start; 1 = preload accumulators from mat_in_accum
mat_in_accum  in  DATA_WIDTH x [NUM_ROWS_A][NUM_COLS_B]  bias matrix, sampled with start
in_valid  in  1  chunk valid
in_ready  out  1  chunk accepted when in_valid & in_ready
mat_a_chunk  in  DATA_WIDTH x [NUM_ROWS_A][K_CHUNK]  A columns of current chunk
mat_b_chunk  in  DATA_WIDTH x [K_CHUNK][NUM_COLS_B]  B rows of current chunk
out_valid  out  1  result valid
out_ready  in  1  result consumed when out_valid & out_ready
mat_out  out  DATA_WIDTH x [NUM_ROWS_A][NUM_COLS_B]  result
sat_flag  out  1  any element of current result saturated
busy  out  1  state != IDLE

Behaviour:
- Reset (asynchronous, active-low, any time including mid-job):
  - state=IDLE; accumulators, product registers, chunk counter and mat_out = 0.
  - out_valid, sat_flag, in_ready and busy = 0.
- States: IDLE, LOAD, DRAIN, DONE.
- IDLE:
  - start=1 -> accumulators := bias_en ? sign-extend(mat_in_accum) << FIXED_PNT : 0; chunk_cnt := 0; sat_flag := 0; next state LOAD.
  - in_valid is ignored.
- LOAD:
  - in_ready=1 (combinational on state only).
  - Per accepted beat: per cell, sum over K_CHUNK of full 2*DATA_WIDTH signed products, registered (stage 1, p_valid=1); chunk_cnt++.
  - Next cycle (stage 2) the registered sum is added to the ACC_WIDTH accumulator.
  - On accepting beat NUM_CHUNKS-1 -> DRAIN.
  - Gaps in in_valid are allowed; no timeout.
- DRAIN: in_ready=0. Once the final stage-2 add has completed, per cell:
  - Round: r = (acc + 2^(FIXED_PNT-1)) >>> FIXED_PNT (round half toward +inf).
  - Saturate r to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; register into mat_out.
  - sat_flag := OR of per-cell clip indications.
  - Next state DONE.
- Latency: handshake of the last beat at edge N -> out_valid=1 after edge N+2.
- DONE:
  - out_valid=1; mat_out and sat_flag held stable until out_ready=1.
  - On handshake -> IDLE; out_valid=0 next cycle.
  - mat_out and sat_flag retain their values until the next start (sat_flag) or next result (mat_out).
- start outside IDLE is ignored, including start coincident with the out handshake. New jobs start no earlier than the cycle after return to IDLE.
- in_ready=0 in IDLE, DRAIN and DONE. Input data is never consumed without a handshake.
- Width rule: ACC_WIDTH >= 2*DATA_WIDTH + clog2(K_TOTAL+1) + 1. Violation is an elaboration-time fatal. The accumulator never wraps.

Decomposition:
- Package mmu_pkg:
  - state enum (IDLE/LOAD/DRAIN/DONE)
  - localparam K_TOTAL
  - function round_sat(acc) returning {sat, value}
  - ACC_WIDTH check function
- Sub-module mmu_acc_cell, one instance per output cell:
  - chunk dot product, stage-1 register, accumulator, round/saturate, output register
  - driven by load_bias/accum_en/finish strobes from the top-level FSM

Test Plan:
1. bias_en=0, every chunk: A all 0x0100, B all 0x0100 -> mat_out all 0x0800, sat_flag=0, out_valid exactly 2 cycles after 4th beat handshake.
2. bias_en=1, mat_in_accum all 0x0080, A all 0x0100, B all 0x0080 -> mat_out all 0x0480.
3. A all 0x7FFF, B all 0x7FFF -> mat_out all 0x7FFF, sat_flag=1. B all 0x8000 (A unchanged) -> all 0x8000, sat_flag=1. Next clean job clears sat_flag.
4. Rounding, one chunk with A[0][0]=0x0001, rest zero:
   - B[0][0]=0x0080 -> mat_out[0][0]=0x0001.
   - B[0][0]=0x007F -> 0x0000.
   - B[0][0]=0xFF80 -> 0x0000.
5. Backpressure:
   - in_valid toggled 1/0 per cycle -> result identical to test 1.
   - out_ready low for 5 cycles -> out_valid and mat_out stable, in_ready=0, start pulse ignored (busy stays 1).
6. rst_n asserted after 2 accepted beats -> all outputs 0 immediately, busy=0. Fresh job per test 1 -> 0x0800.
